// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate L1 data cache with one 64-bit word per line.
// Loads that miss and all stores go to the memory bus over a registered req/ack handshake.
module dcache_ctrl #(
  parameter int NUM_SETS = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dcache_en,
  input  logic        dcache_wren,
  input  logic [63:0] dcache_addr,
  input  logic [63:0] dcache_wdata,
  output logic [63:0] dcache_rdata,
  output logic        dcache_done,
  output logic        bus_req,
  output logic        bus_wren,
  output logic [63:0] bus_addr,
  output logic [63:0] bus_wdata,
  input  logic [63:0] bus_rdata,
  input  logic        bus_ack
);

  localparam int IDX_W = $clog2(NUM_SETS);
  localparam int TAG_W = 64 - 3 - IDX_W;

  // Bus handshake: bus_req rises with address/data/wren already stable and holds
  // them unchanged until the one-cycle bus_ack; bus_ack while bus_req=0 is ignored.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOOKUP = 3'd1,
    FILL   = 3'd2,
    WRITE  = 3'd3,
    RESP   = 3'd4
  } state_t;

  state_t state, state_n;

  logic [NUM_SETS-1:0] valid;
  logic [TAG_W-1:0]    tag_mem  [NUM_SETS];
  logic [63:0]         data_mem [NUM_SETS];

  logic [63:0]      addr_q;
  logic             wren_q;
  logic [63:0]      wdata_q;
  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic             hit;

  logic        latch_req;
  logic        line_fill;
  logic        line_write;
  logic        bus_req_n;
  logic        bus_wren_n;
  logic [63:0] bus_addr_n;
  logic [63:0] bus_wdata_n;
  logic [63:0] rdata_n;
  logic        done_n;

  assign idx = addr_q[3 +: IDX_W];
  assign tag = addr_q[63 -: TAG_W];
  assign hit = valid[idx] && (tag_mem[idx] == tag);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // done_n is raised on every transition into RESP so the registered pulse
  // lines up exactly with the RESP cycle.
  always_comb begin
    state_n     = state;
    latch_req   = 1'b0;
    line_fill   = 1'b0;
    line_write  = 1'b0;
    bus_req_n   = bus_req;
    bus_wren_n  = bus_wren;
    bus_addr_n  = bus_addr;
    bus_wdata_n = bus_wdata;
    rdata_n     = dcache_rdata;
    done_n      = 1'b0;
    case (state)
      IDLE: begin
        if (dcache_en) begin
          latch_req = 1'b1;
          state_n   = LOOKUP;
        end
      end
      LOOKUP: begin
        if (wren_q) begin
          bus_req_n   = 1'b1;
          bus_wren_n  = 1'b1;
          bus_addr_n  = addr_q;
          bus_wdata_n = wdata_q;
          line_write  = hit;
          state_n     = WRITE;
        end else if (hit) begin
          rdata_n = data_mem[idx];
          done_n  = 1'b1;
          state_n = RESP;
        end else begin
          bus_req_n  = 1'b1;
          bus_wren_n = 1'b0;
          bus_addr_n = addr_q;
          state_n    = FILL;
        end
      end
      FILL: begin
        if (bus_ack) begin
          line_fill = 1'b1;
          rdata_n   = bus_rdata;
          bus_req_n = 1'b0;
          done_n    = 1'b1;
          state_n   = RESP;
        end
      end
      WRITE: begin
        if (bus_ack) begin
          bus_req_n = 1'b0;
          done_n    = 1'b1;
          state_n   = RESP;
        end
      end
      RESP: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Request capture and registered outputs; the byte offset is cleared at capture
  // so the bus address is word-aligned by construction.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q       <= '0;
      wren_q       <= 1'b0;
      wdata_q      <= '0;
      bus_req      <= 1'b0;
      bus_wren     <= 1'b0;
      bus_addr     <= '0;
      bus_wdata    <= '0;
      dcache_rdata <= '0;
      dcache_done  <= 1'b0;
    end else begin
      if (latch_req) begin
        addr_q  <= {dcache_addr[63:3], 3'b000};
        wren_q  <= dcache_wren;
        wdata_q <= dcache_wdata;
      end
      bus_req      <= bus_req_n;
      bus_wren     <= bus_wren_n;
      bus_addr     <= bus_addr_n;
      bus_wdata    <= bus_wdata_n;
      dcache_rdata <= rdata_n;
      dcache_done  <= done_n;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= '0;
    end else if (line_fill) begin
      valid[idx] <= 1'b1;
    end
  end

  // Tag and data arrays carry no reset; the valid bits alone qualify them.
  always_ff @(posedge clk) begin
    if (line_fill) begin
      tag_mem[idx]  <= tag;
      data_mem[idx] <= bus_rdata;
    end else if (line_write) begin
      data_mem[idx] <= wdata_q;
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Bench for dcache_ctrl: a table of directed load/store vectors with an inline bus
// responder, plus hand-written back-to-back and reset-during-fill sequences.
module tb_dcache_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        dcache_en;
  logic        dcache_wren;
  logic [63:0] dcache_addr;
  logic [63:0] dcache_wdata;
  logic [63:0] dcache_rdata;
  logic        dcache_done;
  logic        bus_req;
  logic        bus_wren;
  logic [63:0] bus_addr;
  logic [63:0] bus_wdata;
  logic [63:0] bus_rdata;
  logic        bus_ack;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic        wren;
    logic [63:0] addr;
    logic [63:0] wdata;
    int          delay;
    logic [63:0] brdata;
    logic        exp_bus;
    logic [63:0] exp_baddr;
    logic [63:0] exp_rdata;
  } vec_t;

  vec_t vecs[$];

  dcache_ctrl #(.NUM_SETS(64)) dut (
    .clk          (clk),
    .reset        (reset),
    .dcache_en    (dcache_en),
    .dcache_wren  (dcache_wren),
    .dcache_addr  (dcache_addr),
    .dcache_wdata (dcache_wdata),
    .dcache_rdata (dcache_rdata),
    .dcache_done  (dcache_done),
    .bus_req      (bus_req),
    .bus_wren     (bus_wren),
    .bus_addr     (bus_addr),
    .bus_wdata    (bus_wdata),
    .bus_rdata    (bus_rdata),
    .bus_ack      (bus_ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic wren, input logic [63:0] addr, input logic [63:0] wdata,
                         input int delay, input logic [63:0] brdata, input logic exp_bus,
                         input logic [63:0] exp_baddr, input logic [63:0] exp_rdata);
    vec_t v;
    v.wren = wren; v.addr = addr; v.wdata = wdata; v.delay = delay; v.brdata = brdata;
    v.exp_bus = exp_bus; v.exp_baddr = exp_baddr; v.exp_rdata = exp_rdata;
    vecs.push_back(v);
  endtask

  // Drives one request, acks any bus request after v.delay cycles, and checks the
  // bus transaction, completion latency, load data and the absence of a second pulse.
  task automatic do_req(input vec_t v, input string tag);
    bit          got_done;
    int          lat;
    int          wait_cnt;
    int          bus_cnt;
    logic        prev_req;
    logic        b_wren;
    logic [63:0] b_addr;
    logic [63:0] b_wdata;
    logic [63:0] rd;
    int          exp_lat;
    @(negedge clk);
    dcache_en = 1'b1; dcache_wren = v.wren; dcache_addr = v.addr; dcache_wdata = v.wdata;
    got_done = 0; lat = 0; wait_cnt = -1; bus_cnt = 0; prev_req = 1'b0;
    b_wren = 1'b0; b_addr = '0; b_wdata = '0; rd = '0;
    for (int cyc = 1; cyc <= 60 && !got_done; cyc++) begin
      @(negedge clk);
      bus_ack = 1'b0;
      if (dcache_done) begin
        got_done = 1; lat = cyc; rd = dcache_rdata;
        dcache_en = 1'b0;
      end else if (bus_req) begin
        if (!prev_req) begin
          bus_cnt++;
          b_wren = bus_wren; b_addr = bus_addr; b_wdata = bus_wdata;
          wait_cnt = v.delay;
        end
        if (wait_cnt == 0) begin
          bus_ack = 1'b1; bus_rdata = v.brdata; wait_cnt = -1;
        end else if (wait_cnt > 0) begin
          wait_cnt--;
        end
      end
      prev_req = bus_req;
    end
    dcache_en = 1'b0;
    bus_ack = 1'b0;
    exp_lat = v.exp_bus ? v.delay + 3 : 2;
    check({tag, " done"}, 64'(got_done), 64'd1);
    check({tag, " bus_cnt"}, 64'(bus_cnt), 64'(v.exp_bus));
    if (v.exp_bus && bus_cnt != 0) begin
      check({tag, " bus_wren"}, 64'(b_wren), 64'(v.wren));
      check({tag, " bus_addr"}, b_addr, v.exp_baddr);
      if (v.wren) check({tag, " bus_wdata"}, b_wdata, v.wdata);
    end
    check({tag, " latency"}, 64'(lat), 64'(exp_lat));
    if (!v.wren) check({tag, " rdata"}, rd, v.exp_rdata);
    @(negedge clk);
    check({tag, " single_done"}, 64'(dcache_done), 64'd0);
  endtask

  task automatic wait_done(output int lat);
    lat = -1;
    for (int cyc = 1; cyc <= 40 && lat < 0; cyc++) begin
      @(negedge clk);
      if (dcache_done) lat = cyc;
    end
  endtask

  initial begin
    int          lat;
    bit          seen;
    int          done_cnt;
    vec_t        v;

    reset = 1'b1; dcache_en = 1'b0; dcache_wren = 1'b0; dcache_addr = '0;
    dcache_wdata = '0; bus_rdata = '0; bus_ack = 1'b0;

    // Table: loads/stores with hit/miss, no-allocate, conflicts, offset bits, top of address space.
    add_vec(0, 64'h1000, 0, 3, 64'hDEADBEEF, 1, 64'h1000, 64'hDEADBEEF);
    add_vec(0, 64'h1000, 0, 0, 64'h0,        0, 64'h0,    64'hDEADBEEF);
    add_vec(1, 64'h1000, 64'hCAFE, 1, 64'h0, 1, 64'h1000, 64'h0);
    add_vec(0, 64'h1000, 0, 0, 64'h0,        0, 64'h0,    64'hCAFE);
    add_vec(1, 64'h2000, 64'h55, 0, 64'h0,   1, 64'h2000, 64'h0);
    add_vec(0, 64'h2000, 0, 2, 64'h55AA,     1, 64'h2000, 64'h55AA);
    add_vec(0, 64'h1000, 0, 1, 64'h1111,     1, 64'h1000, 64'h1111);
    add_vec(0, 64'h1200, 0, 1, 64'h2222,     1, 64'h1200, 64'h2222);
    add_vec(0, 64'h1000, 0, 2, 64'h3333,     1, 64'h1000, 64'h3333);
    add_vec(0, 64'h1200, 0, 1, 64'h4444,     1, 64'h1200, 64'h4444);
    add_vec(0, 64'h1008, 0, 0, 64'h77,       1, 64'h1008, 64'h77);
    add_vec(0, 64'h1008, 0, 0, 64'h0,        0, 64'h0,    64'h77);
    add_vec(0, 64'h100F, 0, 0, 64'h0,        0, 64'h0,    64'h77);
    add_vec(1, 64'h100C, 64'h99, 2, 64'h0,   1, 64'h1008, 64'h0);
    add_vec(0, 64'h1008, 0, 0, 64'h0,        0, 64'h0,    64'h99);
    add_vec(0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 4, 64'hA5A5_A5A5_A5A5_A5A5, 1,
            64'hFFFF_FFFF_FFFF_FFF8, 64'hA5A5_A5A5_A5A5_A5A5);
    add_vec(0, 64'hFFFF_FFFF_FFFF_FFF8, 0, 0, 64'h0, 0, 64'h0, 64'hA5A5_A5A5_A5A5_A5A5);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset done", 64'(dcache_done), 64'd0);
    check("reset bus_req", 64'(bus_req), 64'd0);
    check("reset bus_wren", 64'(bus_wren), 64'd0);
    check("reset rdata", dcache_rdata, 64'd0);
    check("reset bus_addr", bus_addr, 64'd0);
    check("reset bus_wdata", bus_wdata, 64'd0);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      do_req(vecs[i], $sformatf("v%0d", i));
    end

    // Back-to-back: en held through done with a new (hit) address presented in the done cycle.
    @(negedge clk);
    dcache_en = 1'b1; dcache_wren = 1'b0; dcache_addr = 64'h1200;
    wait_done(lat);
    check("b2b first latency", 64'(lat), 64'd2);
    check("b2b first rdata", dcache_rdata, 64'h4444);
    dcache_addr = 64'h1008;
    wait_done(lat);
    check("b2b second latency", 64'(lat), 64'd3);
    check("b2b second rdata", dcache_rdata, 64'h99);
    dcache_en = 1'b0;
    @(negedge clk);
    check("b2b no third done", 64'(dcache_done), 64'd0);

    // Reset while a fill is outstanding, then a stale ack.
    @(negedge clk);
    dcache_en = 1'b1; dcache_wren = 1'b0; dcache_addr = 64'h4000;
    seen = 0;
    done_cnt = 0;
    for (int cyc = 0; cyc < 20 && !seen; cyc++) begin
      @(negedge clk);
      if (bus_req) seen = 1;
    end
    check("rst fill bus_req seen", 64'(seen), 64'd1);
    check("rst fill bus_addr", bus_addr, 64'h4000);
    reset = 1'b1; dcache_en = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    check("rst bus_req low", 64'(bus_req), 64'd0);
    if (dcache_done) done_cnt++;
    @(negedge clk);
    if (dcache_done) done_cnt++;
    bus_ack = 1'b1; bus_rdata = 64'hBAD;
    @(negedge clk);
    bus_ack = 1'b0;
    if (dcache_done) done_cnt++;
    repeat (3) begin
      @(negedge clk);
      if (dcache_done) done_cnt++;
    end
    check("rst no done", 64'(done_cnt), 64'd0);
    check("rst stale ack bus_req", 64'(bus_req), 64'd0);

    // Valid bits were cleared: a previously cached line misses, then hits after refill.
    v.wren = 0; v.addr = 64'h1008; v.wdata = 0; v.delay = 1; v.brdata = 64'hBEEF;
    v.exp_bus = 1; v.exp_baddr = 64'h1008; v.exp_rdata = 64'hBEEF;
    do_req(v, "post_rst miss");
    v.exp_bus = 0; v.brdata = 64'h0;
    do_req(v, "post_rst hit");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
